occ_link_supervisor: RTL
========================

Name: occ_link_supervisor

Overview:
- Single-clock FSM that sequences bring-up and recovery of one OCC GTP lane.
- Holds and pulses the GT reset, waits for receiver ready, and requests comma resync.
- Qualifies a stable aligned link before declaring it up. Forces TX IDLE until then.
- Counts consecutive failed attempts and latches a fatal failure once the limit is reached.
- Sits between the GT wrapper and the packet datapath in the RX clock domain.

Parameters:
g_RESET_PULSE, 16, cycles gt_rst_o stays asserted in GT_RESET
g_SYNC_TIMEOUT, 4096, max cycles spent in WAIT_RDY or WAIT_SYNC before declaring a failure
g_STABLE_CYCLES, 256, consecutive clean cycles required in STABILIZE
g_MAX_RETRIES, 8, failed attempts allowed before FAILED (range 1..255)

Ports:
clk_i  in  1  RX user clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  link enable; low forces DISABLED
clr_cnt_i  in  1  synchronous clear of err_cnt_o
rx_rdy_i  in  1  GT receiver ready
rx_synced_i  in  1  comma alignment achieved
rx_buf_err_i  in  1  elastic buffer over/underflow
rx_comma_err_i  in  1  datapath saw a misplaced comma or unexpected K char
gt_rst_o  out  1  GT reset request
rx_resync_o  out  1  one-cycle comma realign request
tx_force_idle_o  out  1  TX must send IDLE words only
link_up_o  out  1  link qualified
fail_o  out  1  retries exhausted
state_o  out  3  current state encoding
retry_cnt_o  out  8  consecutive failed attempts
err_cnt_o  out  16  buffer error count, saturating

Behaviour:
- State encodings:
  - DISABLED=0, GT_RESET=1, WAIT_RDY=2, RESYNC=3, WAIT_SYNC=4, STABILIZE=5, UP=6, FAILED=7.
- Reset (rst_n_i low, asynchronous):
  - state=DISABLED, retry_cnt_o=0, err_cnt_o=0, internal 32-bit timer=0.
  - Outputs follow the DISABLED decode: gt_rst_o=1, tx_force_idle_o=1, others 0.
- Outputs are Moore, decoded from the state register with no extra latency:
  - gt_rst_o=1 in DISABLED and GT_RESET.
  - rx_resync_o=1 only in RESYNC, which lasts exactly 1 cycle.
  - link_up_o=1 only in UP.
  - tx_force_idle_o equals the inverse of link_up_o.
  - fail_o=1 only in FAILED.
- Timer:
  - Cleared on every state change; otherwise increments each cycle.
  - Saturates at its maximum value.
- Priority:
  - enable_i=0 overrides everything: next state DISABLED, retry_cnt_o cleared.
- Transitions (with enable_i=1):
  - DISABLED -> GT_RESET.
  - GT_RESET: after g_RESET_PULSE cycles -> WAIT_RDY.
  - WAIT_RDY: rx_rdy_i=1 -> RESYNC. Timer reaching g_SYNC_TIMEOUT-1 -> failure.
  - RESYNC -> WAIT_SYNC unconditionally.
  - WAIT_SYNC: rx_synced_i=1 -> STABILIZE. Timer at g_SYNC_TIMEOUT-1 or rx_rdy_i=0 -> failure.
  - STABILIZE: any of rx_synced_i=0, rx_rdy_i=0, rx_buf_err_i=1, rx_comma_err_i=1 -> failure. Timer reaching g_STABLE_CYCLES-1 with all inputs clean -> UP.
  - UP: on entry, retry_cnt_o is cleared.
  - UP exits, in priority order, with no retry increment:
    - rx_rdy_i=0 -> GT_RESET
    - rx_buf_err_i=1 -> GT_RESET
    - rx_synced_i=0 or rx_comma_err_i=1 -> RESYNC
  - FAILED: held until enable_i=0.
- Failure handling:
  - If retry_cnt_o+1 >= g_MAX_RETRIES: retry_cnt_o increments and next state is FAILED.
  - Otherwise: retry_cnt_o increments and next state is GT_RESET.
  - retry_cnt_o never wraps.
- err_cnt_o:
  - Increments each cycle rx_buf_err_i=1 while in STABILIZE or UP.
  - Saturates at 16'hFFFF.
  - clr_cnt_i wins over a simultaneous increment.
  - Not cleared by enable_i.
- Simultaneous events:
  - In the same cycle as the STABILIZE timeout, a fault wins: failure, not UP.
- rst_n_i asserted mid-operation:
  - Immediate return to DISABLED with all reset values, including err_cnt_o.

Test Plan:
Settings for all scenarios: g_RESET_PULSE=4, g_SYNC_TIMEOUT=100, g_STABLE_CYCLES=20, g_MAX_RETRIES=3.
1. Clean bring-up: enable_i=1, rx_rdy_i=1 at cycle 10, rx_synced_i=1 two cycles after rx_resync_o -> gt_rst_o high 4 cycles after DISABLED; single rx_resync_o pulse; link_up_o=1 exactly 20 cycles after STABILIZE entry; tx_force_idle_o=0; retry_cnt_o=0.
2. Sync timeout: rx_rdy_i=1, rx_synced_i held 0 -> WAIT_SYNC exits after 100 cycles; retry_cnt_o 1 then 2; after the third timeout state_o=7, fail_o=1, retry_cnt_o=3; enable_i=0 -> state_o=0, retry_cnt_o=0.
3. Comma error at STABILIZE cycle 19 coinciding with the timer limit -> failure: retry_cnt_o=1, state_o=1, link_up_o never asserted.
4. In UP, rx_synced_i low for 1 cycle -> state_o=3 for exactly 1 cycle; rx_resync_o pulse; retry_cnt_o stays 0; link_up_o low until re-qualification.
5. In UP, rx_buf_err_i high for 3 cycles -> next state GT_RESET; err_cnt_o=1 (only the UP cycle counts); preload to 16'hFFFE plus 3 errors -> 16'hFFFF; clr_cnt_i together with an error -> 0.
6. rst_n_i pulsed low mid-STABILIZE (asynchronous, between clock edges) -> state_o=0, gt_rst_o=1, err_cnt_o=0 immediately, before the next clk_i edge.

Source files
------------

// File: rtl/occ_link_supervisor_if.sv
// Status/control bundle between the GT wrapper, the packet datapath and the lane supervisor.
interface occ_link_supervisor_if;
  logic        enable_i;
  logic        clr_cnt_i;
  logic        rx_rdy_i;
  logic        rx_synced_i;
  logic        rx_buf_err_i;
  logic        rx_comma_err_i;
  logic        gt_rst_o;
  logic        rx_resync_o;
  logic        tx_force_idle_o;
  logic        link_up_o;
  logic        fail_o;
  logic [2:0]  state_o;
  logic [7:0]  retry_cnt_o;
  logic [15:0] err_cnt_o;

  // Supervisor side
  modport slave (
    input  enable_i, clr_cnt_i, rx_rdy_i, rx_synced_i, rx_buf_err_i, rx_comma_err_i,
    output gt_rst_o, rx_resync_o, tx_force_idle_o, link_up_o, fail_o,
           state_o, retry_cnt_o, err_cnt_o
  );

  // Environment side (GT wrapper / datapath / control)
  modport master (
    output enable_i, clr_cnt_i, rx_rdy_i, rx_synced_i, rx_buf_err_i, rx_comma_err_i,
    input  gt_rst_o, rx_resync_o, tx_force_idle_o, link_up_o, fail_o,
           state_o, retry_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/occ_link_supervisor.sv
// Bring-up / recovery sequencer for one OCC GTP lane (RX user clock domain).
module occ_link_supervisor #(
  parameter int unsigned g_RESET_PULSE   = 16,
  parameter int unsigned g_SYNC_TIMEOUT  = 4096,
  parameter int unsigned g_STABLE_CYCLES = 256,
  parameter int unsigned g_MAX_RETRIES   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  occ_link_supervisor_if.slave  lnk
);

  localparam int unsigned TIMER_W     = 32;
  localparam int unsigned RETRY_W     = 8;
  localparam int unsigned RETRY_EXT_W = RETRY_W + 1;
  localparam int unsigned ERR_W       = 16;

  localparam logic [TIMER_W-1:0]     RESET_LAST  = TIMER_W'(g_RESET_PULSE - 1);
  localparam logic [TIMER_W-1:0]     SYNC_LAST   = TIMER_W'(g_SYNC_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]     STABLE_LAST = TIMER_W'(g_STABLE_CYCLES - 1);
  localparam logic [RETRY_EXT_W-1:0] RETRY_LIMIT = RETRY_EXT_W'(g_MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_GT_RESET  = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_RESYNC    = 3'd3,
    ST_WAIT_SYNC = 3'd4,
    ST_STABILIZE = 3'd5,
    ST_UP        = 3'd6,
    ST_FAILED    = 3'd7
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [TIMER_W-1:0]       r_timer;
  logic [RETRY_W-1:0]       r_retry;
  logic [RETRY_W-1:0]       w_retry_nxt;
  logic [RETRY_EXT_W-1:0]   w_retry_inc;
  logic [ERR_W-1:0]         r_err;
  logic [ERR_W-1:0]         w_err_nxt;
  logic                     w_fail;
  logic                     w_stab_fault;
  logic                     w_err_count_en;

  logic r_gt_rst, r_resync, r_link_up, r_tx_idle, r_fail;
  logic w_gt_rst_nxt, w_resync_nxt, w_link_up_nxt, w_tx_idle_nxt, w_fail_nxt;

  assign w_retry_inc  = {1'b0, r_retry} + RETRY_EXT_W'(1);
  assign w_stab_fault = !lnk.rx_synced_i || !lnk.rx_rdy_i || lnk.rx_buf_err_i || lnk.rx_comma_err_i;

  // Next-state, retry bookkeeping and Moore output decode of the next state
  always_comb begin
    w_state_nxt   = r_state;
    w_retry_nxt   = r_retry;
    w_fail        = 1'b0;
    w_gt_rst_nxt  = 1'b0;
    w_resync_nxt  = 1'b0;
    w_link_up_nxt = 1'b0;
    w_tx_idle_nxt = 1'b1;
    w_fail_nxt    = 1'b0;

    if (!lnk.enable_i) begin
      w_state_nxt = ST_DISABLED;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_DISABLED:  w_state_nxt = ST_GT_RESET;
        ST_GT_RESET:  if (r_timer == RESET_LAST) w_state_nxt = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          if (lnk.rx_rdy_i)             w_state_nxt = ST_RESYNC;
          else if (r_timer == SYNC_LAST) w_fail     = 1'b1;
        end
        ST_RESYNC:    w_state_nxt = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (lnk.rx_synced_i)                            w_state_nxt = ST_STABILIZE;
          else if (r_timer == SYNC_LAST || !lnk.rx_rdy_i) w_fail      = 1'b1;
        end
        ST_STABILIZE: begin
          // A fault in the same cycle as the qualification limit still counts as a failure
          if (w_stab_fault) begin
            w_fail = 1'b1;
          end else if (r_timer == STABLE_LAST) begin
            w_state_nxt = ST_UP;
            w_retry_nxt = '0;
          end
        end
        ST_UP: begin
          if (!lnk.rx_rdy_i || lnk.rx_buf_err_i)           w_state_nxt = ST_GT_RESET;
          else if (!lnk.rx_synced_i || lnk.rx_comma_err_i) w_state_nxt = ST_RESYNC;
        end
        ST_FAILED:    w_state_nxt = ST_FAILED;
        default:      w_state_nxt = ST_DISABLED;
      endcase

      if (w_fail) begin
        w_state_nxt = (w_retry_inc >= RETRY_LIMIT) ? ST_FAILED : ST_GT_RESET;
        if (r_retry != '1) w_retry_nxt = w_retry_inc[RETRY_W-1:0];
      end
    end

    w_gt_rst_nxt  = (w_state_nxt == ST_DISABLED) || (w_state_nxt == ST_GT_RESET);
    w_resync_nxt  = (w_state_nxt == ST_RESYNC);
    w_link_up_nxt = (w_state_nxt == ST_UP);
    w_tx_idle_nxt = (w_state_nxt != ST_UP);
    w_fail_nxt    = (w_state_nxt == ST_FAILED);
  end

  // Buffer error counter: counts only while qualifying or up, saturating, clear has priority
  assign w_err_count_en = lnk.rx_buf_err_i && ((r_state == ST_STABILIZE) || (r_state == ST_UP));

  always_comb begin
    w_err_nxt = r_err;
    if (lnk.clr_cnt_i)                    w_err_nxt = '0;
    else if (w_err_count_en && r_err != '1) w_err_nxt = r_err + ERR_W'(1);
  end

  // State register with dwell timer (restarts on every state change, saturates)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_DISABLED;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_timer <= '0;
      else if (r_timer != '1)     r_timer <= r_timer + TIMER_W'(1);
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_retry   <= '0;
      r_err     <= '0;
      r_gt_rst  <= 1'b1;
      r_resync  <= 1'b0;
      r_link_up <= 1'b0;
      r_tx_idle <= 1'b1;
      r_fail    <= 1'b0;
    end else begin
      r_retry   <= w_retry_nxt;
      r_err     <= w_err_nxt;
      r_gt_rst  <= w_gt_rst_nxt;
      r_resync  <= w_resync_nxt;
      r_link_up <= w_link_up_nxt;
      r_tx_idle <= w_tx_idle_nxt;
      r_fail    <= w_fail_nxt;
    end
  end

  assign lnk.gt_rst_o        = r_gt_rst;
  assign lnk.rx_resync_o     = r_resync;
  assign lnk.link_up_o       = r_link_up;
  assign lnk.tx_force_idle_o = r_tx_idle;
  assign lnk.fail_o          = r_fail;
  assign lnk.state_o         = r_state;
  assign lnk.retry_cnt_o     = r_retry;
  assign lnk.err_cnt_o       = r_err;

endmodule
